// File: rtl/brownout_rst_seq_if.sv
// ---------------------------------------------------------------------------
// brownout_rst_seq_if
//
// Purpose: groups the detector-side inputs and the firmware/system-side
// outputs of the brownout reset sequencer into one bundle.
//
// Signal semantics (there is no valid/ready handshake on this block):
//   ena, brout, vunder and clr_flags are driven by the master side.
//   brout and vunder are asynchronous levels. ena is a synchronous level.
//   clr_flags is a synchronous one-cycle pulse. All outputs are registered
//   in the sequencer clock domain and are valid every cycle.
//
// Ports (modport slave = sequencer view):
//   ena          in   detector enable (0 = detector off)
//   brout        in   brownout indication, async, 1 = below trip
//   vunder       in   under-voltage indication, async
//   clr_flags    in   clears sticky flags and event counter
//   sys_rst_n    out  stretched active-low system reset
//   brout_flag   out  sticky, set on each counted brownout
//   vunder_flag  out  sticky, set on synchronized vunder rising edge
//   vunder_sync  out  synchronized vunder
//   event_cnt    out  saturating brownout event count
//   state        out  debug FSM state (0 DISABLED, 1 RUN, 2 BROWNOUT, 3 RELEASE)
// ---------------------------------------------------------------------------
interface brownout_rst_seq_if #(
    parameter int CNT_W = 8
);
    logic             ena;
    logic             brout;
    logic             vunder;
    logic             clr_flags;
    logic             sys_rst_n;
    logic             brout_flag;
    logic             vunder_flag;
    logic             vunder_sync;
    logic [CNT_W-1:0] event_cnt;
    logic [1:0]       state;

    modport master (
        output ena, brout, vunder, clr_flags,
        input  sys_rst_n, brout_flag, vunder_flag, vunder_sync, event_cnt, state
    );

    modport slave (
        input  ena, brout, vunder, clr_flags,
        output sys_rst_n, brout_flag, vunder_flag, vunder_sync, event_cnt, state
    );
endinterface

// File: rtl/brownout_rst_seq.sv
// ---------------------------------------------------------------------------
// brownout_rst_seq
//
// Purpose: reset sequencer placed directly after the brownout detector.
// Synchronizes the detector's asynchronous brownout and under-voltage
// indications into the osc_ck domain, generates a stretched glitch-free
// active-low system reset from the brownout indication, and keeps sticky
// status flags plus a saturating brownout event counter for firmware.
//
// Parameters:
//   HOLD_CYCLES  cycles reset is held after brownout clears or after
//                enable/reset (>= 1)
//   CNT_W        width of the brownout event counter
//
// Ports:
//   osc_ck  in   sequencer clock
//   rst     in   asynchronous active-high reset
//   bus     --   brownout_rst_seq_if.slave (see interface header)
// ---------------------------------------------------------------------------
module brownout_rst_seq #(
    parameter int HOLD_CYCLES = 64,
    parameter int CNT_W       = 8
) (
    input  logic                osc_ck,
    input  logic                rst,
    brownout_rst_seq_if.slave   bus
);

    localparam int                HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0]     HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUN      = 2'd1,
        ST_BROWNOUT = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Synchronizer flops
    logic brout_m, brout_s;
    logic vunder_m, vunder_s, vunder_prev;

    // FSM and hold counter
    state_t          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            count_evt;

    // Registered outputs
    logic             sys_rst_n_q;
    logic             brout_flag_q;
    logic             vunder_flag_q;
    logic [CNT_W-1:0] event_cnt_q;

    logic vunder_rise;

    // -----------------------------------------------------------------------
    // 2-flop synchronizers; vunder_prev feeds the rising-edge detector
    // -----------------------------------------------------------------------
    always_ff @(posedge osc_ck or posedge rst) begin
        if (rst) begin
            brout_m     <= 1'b0;
            brout_s     <= 1'b0;
            vunder_m    <= 1'b0;
            vunder_s    <= 1'b0;
            vunder_prev <= 1'b0;
        end else begin
            brout_m     <= bus.brout;
            brout_s     <= brout_m;
            vunder_m    <= bus.vunder;
            vunder_s    <= vunder_m;
            vunder_prev <= vunder_s;
        end
    end

    assign vunder_rise = vunder_s & ~vunder_prev;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge osc_ck or posedge rst) begin
        if (rst) begin
            state_q <= ST_RELEASE;
            hold_q  <= HOLD_LOAD;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state. ena=0 overrides everything. Only RUN->BROWNOUT is a
    // counted event; a re-trip from RELEASE is a continuation of the same
    // brownout.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        count_evt = 1'b0;
        if (!bus.ena) begin
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    state_d = ST_RELEASE;
                    hold_d  = HOLD_LOAD;
                end
                ST_RUN: begin
                    if (brout_s) begin
                        state_d   = ST_BROWNOUT;
                        count_evt = 1'b1;
                    end
                end
                ST_BROWNOUT: begin
                    if (!brout_s) begin
                        state_d = ST_RELEASE;
                        hold_d  = HOLD_LOAD;
                    end
                end
                ST_RELEASE: begin
                    if (brout_s) begin
                        state_d = ST_BROWNOUT;
                    end else if (hold_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                default: begin
                    state_d = ST_RELEASE;
                    hold_d  = HOLD_LOAD;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // sys_rst_n is registered from the next state so it changes on the same
    // edge as the state and never glitches between RELEASE and BROWNOUT.
    // -----------------------------------------------------------------------
    always_ff @(posedge osc_ck or posedge rst) begin
        if (rst) begin
            sys_rst_n_q <= 1'b0;
        end else begin
            sys_rst_n_q <= (state_d == ST_RUN) || (state_d == ST_DISABLED);
        end
    end

    // -----------------------------------------------------------------------
    // Sticky flags and saturating counter. A set/increment in the same cycle
    // as clr_flags wins, leaving the flag set and the counter at 1.
    // -----------------------------------------------------------------------
    always_ff @(posedge osc_ck or posedge rst) begin
        if (rst) begin
            brout_flag_q  <= 1'b0;
            vunder_flag_q <= 1'b0;
            event_cnt_q   <= '0;
        end else begin
            if (count_evt) begin
                brout_flag_q <= 1'b1;
                if (bus.clr_flags) begin
                    event_cnt_q <= CNT_W'(1);
                end else if (event_cnt_q != CNT_MAX) begin
                    event_cnt_q <= event_cnt_q + CNT_W'(1);
                end
            end else if (bus.clr_flags) begin
                brout_flag_q <= 1'b0;
                event_cnt_q  <= '0;
            end

            if (vunder_rise) begin
                vunder_flag_q <= 1'b1;
            end else if (bus.clr_flags) begin
                vunder_flag_q <= 1'b0;
            end
        end
    end

    assign bus.sys_rst_n   = sys_rst_n_q;
    assign bus.brout_flag  = brout_flag_q;
    assign bus.vunder_flag = vunder_flag_q;
    assign bus.vunder_sync = vunder_s;
    assign bus.event_cnt   = event_cnt_q;
    assign bus.state       = state_q;

endmodule

// File: doc/brownout_rst_seq.md
# brownout_rst_seq

Digital reset sequencer directly downstream of the brownout detector. It synchronizes the detector's asynchronous `out` (brownout) and `vunder` indications into the `osc_ck` domain. From the brownout indication it generates a stretched, glitch-free active-low system reset. It also keeps sticky status flags and a saturating brownout event counter for firmware readout.

## Interface
- `HOLD_CYCLES`, default 64: number of `osc_ck` cycles reset is held after brownout clears or after enable/reset; must be ≥1.
- `CNT_W`, default 8: width of the brownout event counter.
- `osc_ck`  in  1  sequencer clock (detector RC oscillator or system clock).
- `rst`  in  1  reset, asynchronous, active-high.
- `ena`  in  1  detector enable, synchronous level; 0 = detector off, inputs ignored.
- `brout`  in  1  brownout indication from detector `out`, asynchronous; 1 = supply below trip.
- `vunder`  in  1  under-voltage indication, asynchronous; 1 = under-voltage.
- `clr_flags`  in  1  synchronous one-cycle pulse; clears flags and counter.
- `sys_rst_n`  out  1  registered system reset, active-low.
- `brout_flag`  out  1  sticky; set on every counted brownout event.
- `vunder_flag`  out  1  sticky; set on each synchronized rising edge of `vunder`.
- `vunder_sync`  out  1  2-flop synchronized `vunder`.
- `event_cnt`  out  CNT_W  saturating count of brownout events.
- `state`  out  2  FSM state (debug): DISABLED=0, RUN=1, BROWNOUT=2, RELEASE=3.

## Operation
- **Synchronizers:** 2-flop synchronizers on `brout` and `vunder`, producing `brout_s` and `vunder_sync`. All logic after them is synchronous to `osc_ck`.
- **Hold counter:** `hold_cnt`, width $clog2(HOLD_CYCLES+1), down-counting.
- **FSM:** next-state evaluation is made in this priority order on each edge.
  - Any state, `ena`=0 → DISABLED.
  - DISABLED, `ena`=1 → RELEASE, `hold_cnt`=HOLD_CYCLES-1.
  - RUN, `brout_s`=1 → BROWNOUT.
    - The RUN→BROWNOUT transition is the only counted event: `event_cnt` += 1 (saturates at 2^CNT_W-1) and `brout_flag` is set.
  - BROWNOUT, `brout_s`=0 → RELEASE, `hold_cnt`=HOLD_CYCLES-1. Otherwise stay in BROWNOUT.
  - RELEASE, `brout_s`=1 → BROWNOUT. Not counted; the counter is not incremented.
  - RELEASE, `hold_cnt`==0 → RUN.
  - RELEASE, otherwise: `hold_cnt` -= 1.
- **sys_rst_n:** registered from the next state.
  - 1 when the next state is RUN or DISABLED.
  - 0 when the next state is BROWNOUT or RELEASE.
- **vunder:** sets `vunder_flag` only. It never affects the FSM or `sys_rst_n`.
  - `vunder_flag` is set on a rising edge of `vunder_sync` (0→1, registered previous value), even while `ena`=0.
- **clr_flags=1:** clears `brout_flag`, `vunder_flag` and `event_cnt`.
  - If a set or increment event occurs in the same cycle, the set wins: the flag becomes 1 and `event_cnt` becomes 1.
- **Retention:** flags and `event_cnt` persist across `ena` toggles. Only `rst` or `clr_flags` clears them.

## Timing
- **Reset values** (`rst`=1, asynchronous):
  - state=RELEASE, `hold_cnt`=HOLD_CYCLES-1, `sys_rst_n`=0.
  - `brout_flag`=0, `vunder_flag`=0, `event_cnt`=0.
  - `vunder_sync`=0; synchronizer flops=0.
- **Power-on release:** with `ena`=1 and `brout`=0, `sys_rst_n` rises on the HOLD_CYCLES-th rising edge after `rst` deasserts.
- **Assert latency:** `brout` rising (setup met) → `sys_rst_n` low on the 3rd `osc_ck` edge (2 sync + 1 register).
- **Release latency:** `brout` falling → RELEASE entered at edge 3 → `sys_rst_n` high at edge 3+HOLD_CYCLES.
- **Pulse requirement:** a `brout` pulse shorter than 1 cycle may be missed. Any pulse seen by `brout_s` for ≥1 cycle in RUN produces a full reset of ≥1+HOLD_CYCLES cycles.
- **Re-trip in RELEASE:** a re-trip during RELEASE restarts the full hold after `brout_s` clears again. `sys_rst_n` stays low throughout, with no glitch.
- **Enable:**
  - `ena` falling → `sys_rst_n`=1 on the next edge, from any state.
  - `ena` rising → `sys_rst_n`=0 on the next edge, then HOLD_CYCLES cycles in RELEASE.
- **Reset mid-operation:** `rst` asserted mid-RELEASE or mid-BROWNOUT immediately forces the reset values; the hold is not resumed.

## Test plan
- **Power-on:** HOLD_CYCLES=4, `ena`=1, `brout`=0, release `rst`.
  - Required: `sys_rst_n` low for edges 1–3 and high at edge 4; state=1; `event_cnt`=0.
- **Single brownout:** in RUN, `brout`=1 for 10 cycles, then 0.
  - Required: `sys_rst_n` low from edge 3 after the rise and high 3+4 edges after the fall.
  - Required: `event_cnt`=1, `brout_flag`=1.
- **Re-trip during RELEASE:** `brout` high again 2 cycles into RELEASE.
  - Required: state returns to 2 with `sys_rst_n` held low; after the final clear there is a full 4-cycle hold; `event_cnt` stays 1.
- **Saturation and clear:** CNT_W=2, 5 separate brownouts.
  - Required: `event_cnt`=3 after the 3rd event and still 3 after the 5th.
  - `clr_flags` pulse → `event_cnt`=0 and `brout_flag`=0.
  - `clr_flags` coinciding with a counted event → `event_cnt`=1 and `brout_flag`=1.
- **Enable toggling:** `ena`=0 while in BROWNOUT with `brout`=1.
  - Required: `sys_rst_n`=1 next edge, state=0; further `brout` toggles give no count.
  - `ena`=1 → `sys_rst_n`=0 for 4 cycles, then state=1.
- **vunder:** `vunder` pulse of 3 cycles with `ena`=0.
  - Required: `vunder_sync` follows with 2-cycle delay; `vunder_flag`=1; `sys_rst_n` unchanged.
  - `rst` asserted mid-RELEASE → all outputs return to their reset values immediately.
